fpadd_issue_sequencer: RTL and testbench

- Shares one FP adder datapath (align -> add -> normalize stages) between NUM_REQ requesters.
- Round-robin arbitration picks one requester; the block then sequences the three stage enables one cycle apart and returns the rounded result with a requester ID.
- Only one operation is in flight at a time. The block sits between the operand sources and the adder stages on the fpbus.

---
 rtl/fpadd_issue_sequencer.sv | 132 +++++++++++++
 tb/tb_fpadd_issue_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_issue_sequencer.sv
// Round-robin issue sequencer sharing one three-stage FP adder between NUM_REQ requesters.
// One operation in flight: accept, pulse align/add/norm enables, then hold the result until taken.
module fpadd_issue_sequencer #(
    parameter int  NUM_REQ = 2,
    parameter int  CNT_W   = 16,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic [31:0]             dp_a,
    output logic [31:0]             dp_b,
    output logic                    dp_align_en,
    output logic                    dp_add_en,
    output logic                    dp_norm_en,
    input  logic [31:0]             dp_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        ops_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]                  r_state;
    logic [ID_W-1:0]             r_ptr;
    logic [ID_W-1:0]             r_owner;
    logic [31:0]                 r_dp_a;
    logic [31:0]                 r_dp_b;
    logic [31:0]                 r_rsp_data;
    logic [ID_W-1:0]             r_rsp_id;
    logic [CNT_W-1:0]            r_ops_done;

    logic [NUM_REQ-1:0][31:0]    w_a;
    logic [NUM_REQ-1:0][31:0]    w_b;
    logic [ID_W-1:0]             w_idx;
    logic [ID_W-1:0]             w_grant;
    logic                        w_grant_vld;
    logic [ID_W-1:0]             w_ptr_nxt;
    logic                        w_accept;
    logic                        w_rsp_hs;
    logic [NUM_REQ-1:0]          w_req_ready;

    assign w_a = req_a;
    assign w_b = req_b;

    // Scan offsets from the top down so the smallest offset from r_ptr is the last (winning) hit.
    always_comb begin
        w_idx       = '0;
        w_grant     = '0;
        w_grant_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_grant     = w_idx;
                w_grant_vld = 1'b1;
            end
        end
    end

    assign w_ptr_nxt = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
    assign w_accept  = (r_state == S_IDLE) && w_grant_vld;
    assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready;

    // Gated by rst_n so no ready escapes while reset holds the block idle.
    always_comb begin
        w_req_ready = '0;
        if (w_accept && rst_n)
            w_req_ready[w_grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_dp_a     <= '0;
            r_dp_b     <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
            r_ops_done <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dp_a  <= w_a[w_grant];
                        r_dp_b  <= w_b[w_grant];
                        r_owner <= w_grant;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: r_state <= S_ADD;
                S_ADD:   r_state <= S_NORM;
                S_NORM: begin
                    r_rsp_data <= dp_result;
                    r_rsp_id   <= r_owner;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_ops_done <= r_ops_done + 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = w_req_ready;
    assign dp_a        = r_dp_a;
    assign dp_b        = r_dp_b;
    assign dp_align_en = (r_state == S_ALIGN);
    assign dp_add_en   = (r_state == S_ADD);
    assign dp_norm_en  = (r_state == S_NORM);
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_data    = r_rsp_data;
    assign rsp_id      = r_rsp_id;
    assign busy        = (r_state != S_IDLE);
    assign ops_done    = r_ops_done;

endmodule

// File: tb/tb_fpadd_issue_sequencer.sv
// Bench for fpadd_issue_sequencer with three requesters and a 4-bit op counter.
// Expected grants, results and counts come from a cycle-budget reference model.
module tb_fpadd_issue_sequencer;

    logic             clk;
    logic             rst_n;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    logic [2:0][31:0] req_a;
    logic [2:0][31:0] req_b;
    logic [31:0]      dp_a;
    logic [31:0]      dp_b;
    logic             dp_align_en;
    logic             dp_add_en;
    logic             dp_norm_en;
    logic [31:0]      dp_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [1:0]       rsp_id;
    logic             busy;
    logic [3:0]       ops_done;

    int n_chk  = 0;
    int n_fail = 0;
    int m_ptr  = 0;
    int m_ops  = 0;

    fpadd_issue_sequencer #(.NUM_REQ(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .dp_a(dp_a), .dp_b(dp_b),
        .dp_align_en(dp_align_en), .dp_add_en(dp_add_en), .dp_norm_en(dp_norm_en),
        .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .ops_done(ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in datapath: the 1.0+2.0 case gives 3.0, anything else a mixing function.
    function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + {b[15:0], b[31:16]};
    endfunction

    assign dp_result = dp_model(dp_a, dp_b);

    function automatic int ref_grant(input logic [2:0] v, input int ptr);
        for (int k = 0; k < 3; k++)
            if (v[2'((ptr + k) % 3)]) return (ptr + k) % 3;
        return -1;
    endfunction

    // Starts on a negedge, ends on the negedge after the response handshake.
    task automatic run_op(input logic [2:0] valid, input int hold, input bit early, output int gid);
        logic [31:0] ea, eb, er;
        logic [2:0]  erdy;
        req_valid = valid;
        rsp_ready = early;
        #1;
        gid  = ref_grant(valid, m_ptr);
        erdy = 3'(1 << gid);
        n_chk++;
        if (req_ready !== erdy) begin
            n_fail++; $display("FAIL accept_ready: got %b expected %b", req_ready, erdy);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL accept_busy: got %b expected 0", busy);
        end
        ea = req_a[2'(gid)];
        eb = req_b[2'(gid)];
        er = dp_model(ea, eb);
        m_ptr = (gid + 1) % 3;
        @(negedge clk);
        req_a[2'(gid)] = $urandom;
        req_b[2'(gid)] = $urandom;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) @(negedge clk);
            n_chk++;
            if ({dp_align_en, dp_add_en, dp_norm_en} !== 3'(3'b100 >> s)) begin
                n_fail++;
                $display("FAIL stage_en[%0d]: got %b expected %b", s,
                         {dp_align_en, dp_add_en, dp_norm_en}, 3'(3'b100 >> s));
            end
            n_chk++;
            if (req_ready !== 3'b000 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stage_ctl[%0d]: ready=%b rsp_valid=%b busy=%b expected 000/0/1",
                         s, req_ready, rsp_valid, busy);
            end
            n_chk++;
            if (dp_a !== ea || dp_b !== eb) begin
                n_fail++;
                $display("FAIL dp_operands[%0d]: got %h/%h expected %h/%h", s, dp_a, dp_b, ea, eb);
            end
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_data !== er || rsp_id !== 2'(gid)) begin
                n_fail++;
                $display("FAIL resp[%0d]: valid=%b data=%h id=%0d expected 1/%h/%0d",
                         h, rsp_valid, rsp_data, rsp_id, er, gid);
            end
            n_chk++;
            if ({dp_align_en, dp_add_en, dp_norm_en} !== 3'b000 || req_ready !== 3'b000 ||
                ops_done !== 4'(m_ops)) begin
                n_fail++;
                $display("FAIL resp_hold[%0d]: en=%b ready=%b ops=%0d expected 000/000/%0d", h,
                         {dp_align_en, dp_add_en, dp_norm_en}, req_ready, ops_done, 4'(m_ops));
            end
            if (h == hold) rsp_ready = 1'b1;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        m_ops++;
        n_chk++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 4'(m_ops)) begin
            n_fail++;
            $display("FAIL after_hs: valid=%b busy=%b ops=%0d expected 0/0/%0d",
                     rsp_valid, busy, ops_done, 4'(m_ops));
        end
    endtask

    task automatic idle_cycle();
        req_valid = 3'b000;
        rsp_ready = 1'b1;
        #1;
        n_chk++;
        if (req_ready !== 3'b000 || busy !== 1'b0 || rsp_valid !== 1'b0 ||
            {dp_align_en, dp_add_en, dp_norm_en} !== 3'b000 || ops_done !== 4'(m_ops)) begin
            n_fail++;
            $display("FAIL idle: ready=%b busy=%b valid=%b ops=%0d expected 000/0/0/%0d",
                     req_ready, busy, rsp_valid, ops_done, 4'(m_ops));
        end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        m_ops = 0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            req_a[i] = $urandom;
            req_b[i] = $urandom;
        end
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b000 || busy !== 1'b0 || rsp_valid !== 1'b0 ||
            {dp_align_en, dp_add_en, dp_norm_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: ready=%b busy=%b valid=%b expected all 0", req_ready, busy, rsp_valid);
        end
        n_chk++;
        if (dp_a !== 32'h0 || dp_b !== 32'h0 || rsp_data !== 32'h0 || rsp_id !== 2'd0 || ops_done !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_regs: dp_a=%h dp_b=%h data=%h id=%0d ops=%0d expected 0",
                     dp_a, dp_b, rsp_data, rsp_id, ops_done);
        end
        rst_n     = 1'b1;
        req_valid = 3'b000;
    endtask

    task automatic test_single_op();
        int g;
        req_a[0] = 32'h3F80_0000;
        req_b[0] = 32'h4000_0000;
        run_op(3'b001, 0, 1'b0, g);
    endtask

    task automatic test_round_robin();
        int g;
        for (int i = 0; i < 6; i++) run_op(3'b011, 0, 1'b0, g);
    endtask

    task automatic test_backpressure();
        int g;
        run_op(3'b110, 10, 1'b0, g);
        idle_cycle();
    endtask

    task automatic test_reset_mid_op();
        req_valid = 3'b010;
        #1;
        n_chk++;
        if (req_ready !== 3'b010) begin
            n_fail++; $display("FAIL midrst_grant: got %b expected 010", req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (dp_add_en !== 1'b1) begin
            n_fail++; $display("FAIL midrst_add: got %b expected 1", dp_add_en);
        end
        rst_n     = 1'b0;
        req_valid = 3'b111;
        m_ptr     = 0;
        m_ops     = 0;
        #1;
        n_chk++;
        if (req_ready !== 3'b000 || busy !== 1'b0 || rsp_valid !== 1'b0 ||
            {dp_align_en, dp_add_en, dp_norm_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_ctl: ready=%b busy=%b valid=%b en=%b expected all 0",
                     req_ready, busy, rsp_valid, {dp_align_en, dp_add_en, dp_norm_en});
        end
        n_chk++;
        if (dp_a !== 32'h0 || dp_b !== 32'h0 || rsp_data !== 32'h0 || rsp_id !== 2'd0 || ops_done !== 4'd0) begin
            n_fail++;
            $display("FAIL midrst_regs: dp_a=%h dp_b=%h data=%h id=%0d ops=%0d expected 0",
                     dp_a, dp_b, rsp_data, rsp_id, ops_done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle_cycle();
    endtask

    task automatic test_ptr_wrap();
        int g;
        run_op(3'b100, 0, 1'b0, g);
        run_op(3'b011, 1, 1'b0, g);
        run_op(3'b111, 0, 1'b0, g);
    endtask

    task automatic test_counter_wrap();
        int g;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            for (int r = 0; r < 3; r++) begin
                req_a[r] = $urandom;
                req_b[r] = $urandom;
            end
            run_op(3'($urandom_range(1, 7)), 0, 1'b0, g);
        end
        n_chk++;
        if (ops_done !== 4'd0) begin
            n_fail++; $display("FAIL counter_wrap: got %0d expected 0", ops_done);
        end
    endtask

    task automatic test_random();
        int  g;
        bit  early;
        for (int i = 0; i < 30; i++) begin
            for (int r = 0; r < 3; r++) begin
                req_a[r] = $urandom;
                req_b[r] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
            end else begin
                early = 1'($urandom_range(0, 1));
                run_op(3'($urandom_range(1, 7)), early ? 0 : int'($urandom_range(0, 3)), early, g);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_ptr_wrap();
        test_counter_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
